// File: rtl/data_ram_ctrl.sv
// Data-memory slave for the MEM stage: latches one request, inserts LATENCY wait states,
// then completes against a word-organised, byte-enabled, big-endian RAM.
module data_ram_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:2] addr_r;
  logic        we_r;
  logic [3:0]  sel_r;
  logic [31:0] data_r;
  logic [31:0] mem_r [DEPTH];

  logic [ADDR_W-1:0] idx_s;
  logic              oor_s;
  logic              exec_s;
  logic [31:0]       mask_s;
  logic [31:0]       rd_word_s;
  logic              unused_s;

  // Expand big-endian byte enables (sel[3] -> bits 31:24) into a bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Decode of the latched request and the combinational stall towards the pipeline.
  always_comb begin
    idx_s     = addr_r[ADDR_W+1:2];
    oor_s     = |addr_r[31:ADDR_W+2];
    exec_s    = (state_r == S_WAIT) && ce_i && (cnt_r == 4'd0);
    mask_s    = lane_mask(sel_r);
    rd_word_s = mem_r[idx_s];
    unused_s  = &{1'b0, addr_i[1:0]};
    if (state_r == S_WAIT) begin
      stall_o = 1'b1;
    end else if (state_r == S_IDLE) begin
      stall_o = ce_i;
    end else begin
      stall_o = 1'b0;
    end
  end

  // Request FSM with registered completion outputs; dropping ce_i while waiting aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 30'd0;
      we_r    <= 1'b0;
      sel_r   <= 4'd0;
      data_r  <= 32'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      data_o  <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          ack_o  <= 1'b0;
          err_o  <= 1'b0;
          data_o <= 32'd0;
          if (ce_i) begin
            addr_r  <= addr_i[31:2];
            we_r    <= we_i;
            sel_r   <= sel_i;
            data_r  <= data_i;
            cnt_r   <= 4'(LATENCY);
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!ce_i) begin
            state_r <= S_IDLE;
          end else if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= S_DONE;
            ack_o   <= 1'b1;
            err_o   <= oor_s;
            data_o  <= (we_r || oor_s) ? 32'd0 : (rd_word_s & mask_s);
          end
        end
        S_DONE: begin
          ack_o   <= 1'b0;
          err_o   <= 1'b0;
          data_o  <= 32'd0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= 4'd0;
          ack_o   <= 1'b0;
          err_o   <= 1'b0;
          data_o  <= 32'd0;
        end
      endcase
    end
  end

  // Array write on the executing edge; unselected lanes keep their old bytes.
  always_ff @(posedge clk) begin
    if (exec_s && we_r && !oor_s && !rst) begin
      mem_r[idx_s] <= (rd_word_s & ~mask_s) | (data_r & mask_s);
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: instance 0 at LATENCY=2, instance 1 at LATENCY=0.
// Directed table, reset corner sequences, then randomized traffic against a word-array model.
module tb_data_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce    [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [3:0]  sel   [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];
  logic        ack   [2];
  logic        stall [2];
  logic        err   [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [2][1024];

  always #5 clk = ~clk;

  data_ram_ctrl #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]), .sel_i(sel[0]),
    .data_i(din[0]), .data_o(dout[0]), .ack_o(ack[0]), .stall_o(stall[0]), .err_o(err[0])
  );

  data_ram_ctrl #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]), .sel_i(sel[1]),
    .data_i(din[1]), .data_o(dout[1]), .ack_o(ack[1]), .stall_o(stall[1]), .err_o(err[1])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] din;
    int          abort_at;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int d, input logic [31:0] a, input logic [3:0] s);
    logic [31:0] r;
    logic [31:0] w;
    r = 32'd0;
    if (a >= 32'h0000_1000) return 32'd0;
    w = ref_mem[d][a[11:2]];
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = w[8*n +: 8];
    return r;
  endfunction

  // One request: ack expected exactly LATENCY+1 edges after acceptance unless aborted.
  task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] dt, input int abort_at, input logic keep,
                        input logic exp_ack, input logic exp_e, input logic [31:0] exp_d,
                        input string nm);
    int lat;
    lat = (d == 0) ? 2 : 0;
    @(negedge clk);
    ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = dt;
    #1;
    chk($sformatf("%s.d%0d.stall_req", nm, d), {31'd0, stall[d]}, 32'd1);
    chk($sformatf("%s.d%0d.ack_idle", nm, d), {31'd0, ack[d]}, 32'd0);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      chk($sformatf("%s.d%0d.stall_wait%0d", nm, d, c), {31'd0, stall[d]}, 32'd1);
      chk($sformatf("%s.d%0d.ack_wait%0d", nm, d, c), {31'd0, ack[d]}, 32'd0);
      if (c == abort_at) begin
        ce[d] = 1'b0;
        repeat (lat + 3) begin
          @(negedge clk);
          chk($sformatf("%s.d%0d.ack_abort", nm, d), {31'd0, ack[d]}, {31'd0, exp_ack});
          chk($sformatf("%s.d%0d.stall_abort", nm, d), {31'd0, stall[d]}, 32'd0);
        end
        return;
      end
    end
    @(negedge clk);
    chk($sformatf("%s.d%0d.ack", nm, d), {31'd0, ack[d]}, {31'd0, exp_ack});
    chk($sformatf("%s.d%0d.stall_done", nm, d), {31'd0, stall[d]}, 32'd0);
    chk($sformatf("%s.d%0d.err", nm, d), {31'd0, err[d]}, {31'd0, exp_e});
    chk($sformatf("%s.d%0d.data", nm, d), dout[d], exp_d);
    if (w && a < 32'h0000_1000) begin
      for (int n = 0; n < 4; n++) if (s[n]) ref_mem[d][a[11:2]][8*n +: 8] = dt[8*n +: 8];
    end
    if (!keep) begin
      ce[d] = 1'b0;
      @(negedge clk);
      chk($sformatf("%s.d%0d.ack_after", nm, d), {31'd0, ack[d]}, 32'd0);
      chk($sformatf("%s.d%0d.err_after", nm, d), {31'd0, err[d]}, 32'd0);
      chk($sformatf("%s.d%0d.data_after", nm, d), dout[d], 32'd0);
      chk($sformatf("%s.d%0d.stall_after", nm, d), {31'd0, stall[d]}, 32'd0);
    end
  endtask

  initial begin
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] dt;
    logic        oor;
    int          ab;
    logic        kp;
    int          lat;

    for (int d = 0; d < 2; d++) begin
      ce[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'd0; sel[d] = 4'd0; din[d] = 32'd0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset.d%0d.ack", d), {31'd0, ack[d]}, 32'd0);
      chk($sformatf("reset.d%0d.err", d), {31'd0, err[d]}, 32'd0);
      chk($sformatf("reset.d%0d.data", d), dout[d], 32'd0);
      chk($sformatf("reset.d%0d.stall", d), {31'd0, stall[d]}, 32'd0);
    end
    rst = 1'b0;

    // Known contents for words 0..63 of both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        do_req(d, 1'b1, 32'(i * 4), 4'hF, 32'hA500_0000 | 32'(i), 0, 1'b0, 1'b1, 1'b0, 32'd0, "init");
      end
    end

    tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b0, 32'h1122_3344};
    tbl[2]  = '{1'b1, 32'h0000_0010, 4'h4, 32'hAABB_CCDD, 0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b0, 32'h11BB_3344};
    tbl[4]  = '{1'b0, 32'h0000_0010, 4'h3, 32'h0000_0000, 0, 1'b1, 1'b0, 32'h0000_3344};
    tbl[5]  = '{1'b0, 32'h0000_1000, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b1, 32'h0000_0000};
    tbl[6]  = '{1'b1, 32'h0000_1010, 4'hF, 32'h5555_5555, 0, 1'b1, 1'b1, 32'h0000_0000};
    tbl[7]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b0, 32'h11BB_3344};
    tbl[8]  = '{1'b1, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 32'h0000_0000};
    tbl[9]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b0, 32'hA500_0008};
    tbl[10] = '{1'b1, 32'h0000_0024, 4'h0, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[11] = '{1'b0, 32'h0000_0024, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b0, 32'hA500_0009};
    tbl[12] = '{1'b0, 32'h0000_0013, 4'h8, 32'h0000_0000, 0, 1'b1, 1'b0, 32'h1100_0000};
    tbl[13] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h0CAF_E123, 0, 1'b1, 1'b0, 32'h0000_0000};
    tbl[14] = '{1'b0, 32'h0000_0FFC, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b0, 32'h0CAF_E123};
    tbl[15] = '{1'b0, 32'h8000_0010, 4'hF, 32'h0000_0000, 0, 1'b1, 1'b1, 32'h0000_0000};
    for (int i = 0; i < 16; i++) begin
      do_req(0, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].din, tbl[i].abort_at, 1'b0,
             tbl[i].exp_ack, tbl[i].exp_err, tbl[i].exp_data, $sformatf("tbl%0d", i));
    end

    // LATENCY=0 back-to-back loads with ce_i held between them.
    do_req(1, 1'b0, 32'h0000_0004, 4'hF, 32'd0, 0, 1'b1, 1'b1, 1'b0, 32'hA500_0001, "b2b_first");
    do_req(1, 1'b0, 32'h0000_0008, 4'hF, 32'd0, 0, 1'b0, 1'b1, 1'b0, 32'hA500_0002, "b2b_second");

    // Async reset in the middle of a store's wait.
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0020; sel[0] = 4'hF; din[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    #2;
    ce[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_wait.ack", {31'd0, ack[0]}, 32'd0);
    chk("rst_wait.stall", {31'd0, stall[0]}, 32'd0);
    chk("rst_wait.data", dout[0], 32'd0);
    #1;
    rst = 1'b0;
    do_req(0, 1'b0, 32'h0000_0020, 4'hF, 32'd0, 0, 1'b0, 1'b1, 1'b0, 32'hA500_0008, "rst_wait_chk");

    // Async reset while the ack is being presented.
    @(negedge clk);
    ce[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_0010; sel[0] = 4'hF; din[0] = 32'd0;
    repeat (4) @(negedge clk);
    chk("rst_done.ack_pre", {31'd0, ack[0]}, 32'd1);
    chk("rst_done.data_pre", dout[0], 32'h11BB_3344);
    #2;
    ce[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_done.ack", {31'd0, ack[0]}, 32'd0);
    chk("rst_done.data", dout[0], 32'd0);
    #1;
    rst = 1'b0;

    // Randomized traffic against the word-array model.
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 2 : 0;
      for (int t = 0; t < 150; t++) begin
        w  = 1'($urandom_range(0, 1));
        s  = 4'($urandom_range(0, 15));
        dt = $urandom;
        if ($urandom_range(0, 7) == 0) a = 32'h0000_1000 + 32'($urandom_range(0, 32'h00FF_FFFF));
        else a = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
        oor = (a >= 32'h0000_1000);
        ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, lat + 1)) : 0;
        kp  = (ab == 0) && (t < 149) && ($urandom_range(0, 3) == 0);
        if (ab != 0)
          do_req(d, w, a, s, dt, ab, 1'b0, 1'b0, 1'b0, 32'd0, "rnd_abort");
        else
          do_req(d, w, a, s, dt, 0, kp, 1'b1, oor, (w || oor) ? 32'd0 : model_load(d, a, s), "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
